// File: rtl/cpu_clk_ctrl.sv
// Run-control and clock-enable generator: programmable divider, halt/run/step modes,
// optional run-to-breakpoint (CLKCTRL_BREAKPOINT_EN) and an executed-cycle counter.
module cpu_clk_ctrl #(
  parameter int unsigned DIV_W    = 32,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned DIV_BASE = 2,
  parameter int unsigned CYC_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] div_sel,
  input  logic             step_btn,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      bp_addr,
  output logic [DIV_W-1:0] clkd_out,
  output logic             cpu_en,
  output logic [CYC_W-1:0] cyc_cnt,
  output logic             halted,
  output logic             bp_hit
);

  typedef enum logic [2:0] {
    S_HALT,
    S_RUN,
    S_STEP,
    S_BPRUN,
    S_BPSTOP
  } state_t;

  state_t           state, next_state;
  logic [DIV_W-1:0] tick_mask;
  logic             tick;
  logic             step_s1, step_s2, step_s3, step_edge_q;
  logic             bp_match;
  logic             en_d;
  int unsigned      k;

  function automatic state_t decode_mode(input logic [1:0] m);
    case (m)
      2'b00:   decode_mode = S_HALT;
      2'b01:   decode_mode = S_RUN;
      2'b10:   decode_mode = S_STEP;
`ifdef CLKCTRL_BREAKPOINT_EN
      default: decode_mode = S_BPRUN;
`else
      default: decode_mode = S_RUN;
`endif
    endcase
  endfunction

  // Tick is a pure function of the current count, so a div_sel change can only
  // move the next match point and never produce a short pulse.
  always_comb begin
    k = DIV_BASE + 32'(div_sel);
    if (k > DIV_W) k = DIV_W;
    tick_mask = '0;
    for (int unsigned i = 0; i < DIV_W; i++) tick_mask[i] = (i < k);
  end

  assign tick = &(clkd_out | ~tick_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) clkd_out <= '0;
    else     clkd_out <= clkd_out + DIV_W'(1);
  end

  // Two-flop synchroniser, then a registered rising-edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_s1     <= 1'b0;
      step_s2     <= 1'b0;
      step_s3     <= 1'b0;
      step_edge_q <= 1'b0;
    end else begin
      step_s1     <= step_btn;
      step_s2     <= step_s1;
      step_s3     <= step_s2;
      step_edge_q <= step_s2 & ~step_s3;
    end
  end

`ifdef CLKCTRL_BREAKPOINT_EN
  assign bp_match = (pc_in == bp_addr);
`else
  logic unused_bp;
  assign bp_match  = 1'b0;
  assign unused_bp = ^{pc_in, bp_addr};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_HALT;
    else     state <= next_state;
  end

  always_comb begin
    next_state = decode_mode(mode);
`ifdef CLKCTRL_BREAKPOINT_EN
    if (state == S_BPSTOP && mode == 2'b11)
      next_state = S_BPSTOP;
    else if (state == S_BPRUN && tick && bp_match)
      next_state = S_BPSTOP;
`endif
  end

  always_comb begin
    en_d = 1'b0;
    case (state)
      S_RUN:   en_d = tick;
      S_STEP:  en_d = step_edge_q;
      S_BPRUN: en_d = tick & ~bp_match;
      default: en_d = 1'b0;
    endcase
  end

  // Status flags are registered from next_state so they track the state
  // register while still reading 0 during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_en  <= 1'b0;
      cyc_cnt <= '0;
      halted  <= 1'b0;
    end else begin
      cpu_en  <= en_d;
      cyc_cnt <= cyc_cnt + CYC_W'(cpu_en);
      halted  <= (next_state == S_HALT) || (next_state == S_BPSTOP);
    end
  end

`ifdef CLKCTRL_BREAKPOINT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bp_hit <= 1'b0;
    else     bp_hit <= (next_state == S_BPSTOP);
  end
`else
  assign bp_hit = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Randomized bench for cpu_clk_ctrl against a cycle-level behavioural model,
// plus directed run, step, breakpoint and asynchronous-reset scenarios.
module tb_cpu_clk_ctrl;

  localparam int unsigned DIV_W    = 32;
  localparam int unsigned SEL_W    = 4;
  localparam int unsigned DIV_BASE = 2;
  localparam int unsigned CYC_W    = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       mode = 2'b00;
  logic [SEL_W-1:0] div_sel = '0;
  logic             step_btn = 1'b0;
  logic [31:0]      pc_in = '0;
  logic [31:0]      bp_addr = '0;
  logic [DIV_W-1:0] clkd_out;
  logic             cpu_en;
  logic [CYC_W-1:0] cyc_cnt;
  logic             halted;
  logic             bp_hit;

  int n_vec = 0;
  int n_err = 0;

  cpu_clk_ctrl #(.DIV_W(DIV_W), .SEL_W(SEL_W), .DIV_BASE(DIV_BASE), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .div_sel(div_sel), .step_btn(step_btn),
    .pc_in(pc_in), .bp_addr(bp_addr), .clkd_out(clkd_out), .cpu_en(cpu_en),
    .cyc_cnt(cyc_cnt), .halted(halted), .bp_hit(bp_hit)
  );

  always #5 clk = ~clk;

  // Model: elapsed-cycle count, last sampled mode, breakpoint-stopped flag,
  // history of sampled button levels (bit i = sample taken i+1 edges ago).
  logic [31:0] m_cnt, m_cyc;
  logic [1:0]  m_mode;
  bit          m_stop, m_en, m_halt, m_bp;
  bit [3:0]    m_hist;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = '0; m_cyc = '0; m_mode = 2'b00;
    m_stop = 0; m_en = 0; m_halt = 0; m_bp = 0; m_hist = '0;
  endtask

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_edge();
    int unsigned    kk;
    longint unsigned per;
    bit tick, press, pulse, stop_n;
    kk = DIV_BASE + int'(div_sel);
    if (kk > DIV_W) kk = DIV_W;
    per   = 64'd1 << kk;
    tick  = (longint'(m_cnt) % per) == per - 1;
    press = m_hist[2] && !m_hist[3];
    pulse = 0;
    stop_n = 0;
    if (!m_stop) begin
      case (m_mode)
        2'd1: pulse = tick;
        2'd2: pulse = press;
`ifdef CLKCTRL_BREAKPOINT_EN
        2'd3: pulse = tick && (pc_in != bp_addr);
`else
        2'd3: pulse = tick;
`endif
        default: pulse = 0;
      endcase
    end
`ifdef CLKCTRL_BREAKPOINT_EN
    if (m_stop) stop_n = (mode == 2'd3);
    else        stop_n = (m_mode == 2'd3) && tick && (pc_in == bp_addr);
`endif
    m_cyc  = m_cyc + 32'(m_en);
    m_en   = pulse;
    m_stop = stop_n;
    m_halt = stop_n || (mode == 2'd0);
    m_bp   = stop_n;
    m_mode = mode;
    m_cnt  = m_cnt + 1;
    m_hist = {m_hist[2:0], step_btn};
  endtask

  // One clock: update model, let the edge happen, compare at the falling edge.
  task automatic cyc1();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("cpu_en",   64'(cpu_en),   64'(m_en));
    chk("clkd_out", 64'(clkd_out), 64'(m_cnt));
    chk("cyc_cnt",  64'(cyc_cnt),  64'(m_cyc));
    chk("halted",   64'(halted),   64'(m_halt));
    chk("bp_hit",   64'(bp_hit),   64'(m_bp));
    if (m_en) pc_in = pc_in + 32'd4;
  endtask

  task automatic run_count(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      cyc1();
      if (cpu_en) pulses++;
    end
  endtask

  initial begin
    int p;
    logic [CYC_W-1:0] c0;
    int seg_left, btn_left;

    model_reset();
    #1;
    chk("rst_cpu_en",   64'(cpu_en),   64'd0);
    chk("rst_clkd_out", 64'(clkd_out), 64'd0);
    chk("rst_cyc_cnt",  64'(cyc_cnt),  64'd0);
    chk("rst_halted",   64'(halted),   64'd0);
    chk("rst_bp_hit",   64'(bp_hit),   64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Run at the fastest base rate: 10 pulses in any 40-cycle window.
    mode = 2'b01; div_sel = '0;
    for (int i = 0; i < 8; i++) cyc1();
    c0 = cyc_cnt;
    run_count(40, p);
    chk("run40_pulses", 64'(p), 64'd10);
    chk("run40_cyc",    64'(cyc_cnt - c0), 64'd10);

    // Three step presses held 5 cycles each.
    mode = 2'b10;
    for (int i = 0; i < 6; i++) cyc1();
    c0 = cyc_cnt;
    p = 0;
    for (int n = 0; n < 3; n++) begin
      int q;
      step_btn = 1'b1; run_count(5, q); p += q;
      step_btn = 1'b0; run_count(8, q); p += q;
    end
    chk("step3_pulses", 64'(p), 64'd3);
    for (int i = 0; i < 2; i++) cyc1();
    chk("step3_cyc", 64'(cyc_cnt - c0), 64'd3);

    // Button held for 100 cycles yields a single step.
    step_btn = 1'b1;
    run_count(100, p);
    step_btn = 1'b0;
    begin
      int q;
      run_count(6, q);
      chk("step_hold_pulses", 64'(p + q), 64'd1);
    end

`ifdef CLKCTRL_BREAKPOINT_EN
    // Run to breakpoint at 0xC with pc advancing 4 per pulse from 0.
    mode = 2'b00;
    for (int i = 0; i < 3; i++) cyc1();
    pc_in = 32'h0; bp_addr = 32'hC; div_sel = '0;
    c0 = cyc_cnt;
    mode = 2'b11;
    run_count(60, p);
    chk("bp_pulses", 64'(p), 64'd3);
    chk("bp_hit",    64'(bp_hit), 64'd1);
    chk("bp_halted", 64'(halted), 64'd1);
    chk("bp_cyc",    64'(cyc_cnt - c0), 64'd3);
    mode = 2'b10;
    for (int i = 0; i < 4; i++) cyc1();
    step_btn = 1'b1; run_count(4, p);
    step_btn = 1'b0;
    begin
      int q;
      run_count(6, q);
      chk("bp_step_pulses", 64'(p + q), 64'd1);
    end
    chk("bp_step_bp_hit", 64'(bp_hit), 64'd0);
`endif

    // Randomized segments of mode, divider and button activity.
    seg_left = 0; btn_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg_left == 0) begin
        mode     = 2'($urandom_range(0, 3));
        div_sel  = ($urandom_range(0, 7) == 0) ? SEL_W'($urandom_range(0, 6))
                                               : SEL_W'($urandom_range(0, 3));
        bp_addr  = 32'($urandom_range(0, 7)) << 2;
        if ($urandom_range(0, 2) == 0) pc_in = '0;
        seg_left = $urandom_range(20, 150);
      end else if ($urandom_range(0, 63) == 0) begin
        div_sel = SEL_W'($urandom_range(0, 3));
      end
      seg_left--;
      if (btn_left > 0) begin
        btn_left--;
        if (btn_left == 0) step_btn = 1'b0;
      end else if (!step_btn && $urandom_range(0, 9) == 0) begin
        step_btn = 1'b1;
        btn_left = $urandom_range(1, 8);
      end
      cyc1();
    end

    // Asynchronous reset in the middle of a run.
    step_btn = 1'b0; mode = 2'b01; div_sel = '0;
    for (int i = 0; i < 12; i++) cyc1();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_cpu_en",   64'(cpu_en),   64'd0);
    chk("arst_clkd_out", 64'(clkd_out), 64'd0);
    chk("arst_cyc_cnt",  64'(cyc_cnt),  64'd0);
    @(negedge clk);
    mode = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc1();
    chk("arst_halted_after", 64'(halted), 64'd1);
    for (int i = 0; i < 5; i++) cyc1();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_clk_ctrl.md
# cpu_clk_ctrl

Run-control and clock-enable generator for the pipelined CPU top level. It replaces the fixed free-running divider: a parametrised divider produces a one-cycle CPU clock-enable pulse whose rate is set from the board switches. A small state machine adds halt, single-step (push button) and run-to-breakpoint modes. An executed-cycle counter feeds the board displays alongside PC and instruction.

## Interface
Parameters:
- DIV_W, 32, width of the free-running divider counter `clkd_out`
- SEL_W, 4, width of `div_sel`
- DIV_BASE, 2, minimum log2 divide ratio
- CYC_W, 32, width of the executed-cycle counter

Ports:
- clk  in  1  board clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- mode  in  2  00 halt, 01 run, 10 step, 11 run-to-breakpoint
- div_sel  in  SEL_W  log2 divide ratio above DIV_BASE
- step_btn  in  1  raw step push button, asynchronous to clk
- pc_in  in  32  current CPU PC
- bp_addr  in  32  breakpoint address
- clkd_out  out  DIV_W  free-running divider count
- cpu_en  out  1  CPU clock enable, one-cycle pulse
- cyc_cnt  out  CYC_W  number of cpu_en pulses issued
- halted  out  1  high in HALT or BP_STOP
- bp_hit  out  1  high in BP_STOP

## Operation
- Reset values: all outputs are 0. State is HALT. Synchroniser flops are 0.
- Divider:
  - `clkd_out` increments by 1 every clk and wraps from all-ones to 0.
  - k = min(DIV_BASE+div_sel, DIV_W).
  - tick is high in a cycle when `clkd_out[k-1:0]` is all ones.
  - The period is 2^k clk.
  - div_sel may change at any time; the new period applies from the next matching count, with no glitch pulse.
- Step input:
  - step_btn passes through a 2-flop synchroniser.
  - A rising edge is detected on the synchronised value.
  - A step edge arriving in any mode other than STEP is discarded.
- States:
  - HALT: no pulses.
  - RUN: cpu_en follows tick.
  - STEP: one cpu_en per step edge; tick is ignored.
  - BPRUN: as RUN, but a tick with pc_in==bp_addr is suppressed. The FSM then goes to BP_STOP and no pulse is issued.
  - BP_STOP: no pulses.
- Transitions:
  - From HALT, RUN, STEP or BPRUN, the next state is decoded from mode (00 HALT, 01 RUN, 10 STEP, 11 BPRUN).
  - BP_STOP is left only when mode != 11. The next state is then decoded from mode.
  - Returning to mode 11 while pc_in still equals bp_addr stops again on the first tick. The user steps past the breakpoint.
- cyc_cnt increments by 1 on every cpu_en pulse and wraps at 2^CYC_W.

## Timing
- cpu_en is registered: cpu_en(n+1) is computed from state(n), tick(n), step edge(n), pc_in(n) and mode(n).
- Mode changes take effect one cycle after being sampled.
- A tick in the same cycle as a mode change is evaluated against the old state.
- Step latency:
  - step_btn is first sampled high at edge e.
  - cpu_en is high in the cycle starting at edge e+3.
  - Exactly one pulse per press.
- Breakpoint stop:
  - The tick cycle with a match has no pulse.
  - bp_hit and halted go high at the next edge.
  - cyc_cnt is unchanged.
- cpu_en is never high for two consecutive cycles, except with k=1 in RUN.
- cyc_cnt updates on the same edge that drops cpu_en.
- Reset asserted mid-run:
  - cpu_en drops immediately (asynchronous).
  - Counters clear immediately.
  - Operation resumes in HALT after release.

## Configuration
- CLKCTRL_BREAKPOINT_EN defined:
  - BPRUN and BP_STOP exist as described.
  - bp_hit is driven from the FSM.
- Not defined:
  - mode 11 behaves exactly as RUN.
  - The comparator and BP_STOP are removed.
  - bp_hit is tied to 0.
  - pc_in and bp_addr are unused.

## Test plan
- Reset, then mode=01, div_sel=0, DIV_BASE=2 -> cpu_en pulses every 4 clk; cyc_cnt=10 after 40 clk of run.
- mode=01, switch div_sel 0->3 mid-run -> pulse spacing changes from 4 to 32 clk; no extra or short pulse.
- mode=10, press step_btn three times (each held 5 clk) -> exactly 3 pulses, each 3 cycles after the first high sample; cyc_cnt=3.
- mode=10, step_btn held high for 100 clk -> exactly 1 pulse.
- Breakpoint test, with CLKCTRL_BREAKPOINT_EN defined:
  - Setup: mode=11, bp_addr=0x0000000C, pc_in advanced by 4 on each pulse starting at 0.
  - Expected: 3 pulses; bp_hit=1 and halted=1 when pc_in=0xC; cyc_cnt=3.
  - Then mode=10 with one step: 1 pulse, bp_hit=0.
- Reset mid-run: assert rst during RUN -> cpu_en, clkd_out, cyc_cnt=0 without waiting for clk; after release, halted=1.
